// File: rtl/jtag_scan_master.sv
// jtag_scan_master: JTAG initiator running one IR, DR or IR-then-DR scan per command, RTI to RTI.
// TCK period is CLK_DIV clk low then CLK_DIV clk high; TDO is sampled on the clk where TCK rises.
module jtag_scan_master #(
    parameter int CLK_DIV = 2,
    parameter int IR_W    = 4,
    parameter int DR_MAXW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               do_ir,
    input  logic               do_dr,
    input  logic [IR_W-1:0]    ir_in,
    input  logic [5:0]         dr_len,
    input  logic [DR_MAXW-1:0] dr_in,
    output logic               busy,
    output logic               done,
    output logic [IR_W-1:0]    ir_out,
    output logic [DR_MAXW-1:0] dr_out,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    output logic               TRST_N,
    input  logic               TDO
);
    localparam int BW = $clog2(((DR_MAXW > IR_W) ? DR_MAXW : IR_W) + 1);
    localparam int CW = $clog2(2 * CLK_DIV + 1);

    typedef enum logic [3:0] {
        RESET_SEQ, IDLE, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL, FINISH
    } state_t;

    state_t              r_state, w_state_nxt, w_seq_nxt;
    logic [BW-1:0]       r_bit, w_bit_nxt, w_last_idx, w_len, r_n;
    logic [CW-1:0]       r_cnt;
    logic                r_tck, r_trst_n, r_busy, r_done, r_do_dr;
    logic [IR_W-1:0]     r_ir, r_ir_out;
    logic [DR_MAXW-1:0]  r_dr, r_dr_out;
    logic                w_accept, w_run, w_end, w_rise, w_last;

    assign w_accept = (r_state == IDLE) && start;
    assign w_run    = (r_state != IDLE) && (r_state != FINISH);
    assign w_end    = r_cnt == CW'(2 * CLK_DIV);
    assign w_rise   = r_cnt == CW'(CLK_DIV);
    assign w_len    = (dr_len == 6'd0) ? BW'(1) :
                      (int'(dr_len) > DR_MAXW) ? BW'(DR_MAXW) : BW'(dr_len);

    // Index of the final TCK in the current state's segment
    assign w_last_idx = (r_state == RESET_SEQ) ? BW'(5) :
                        (r_state == IR_HDR)    ? BW'(3) :
                        (r_state == IR_SHIFT)  ? BW'(IR_W - 1) :
                        (r_state == DR_HDR)    ? BW'(2) :
                        (r_state == DR_SHIFT)  ? r_n - BW'(1) : BW'(1);
    assign w_last = r_bit == w_last_idx;

    assign w_seq_nxt = (r_state == RESET_SEQ) ? IDLE :
                       (r_state == IR_HDR)    ? IR_SHIFT :
                       (r_state == IR_SHIFT)  ? IR_TAIL :
                       (r_state == IR_TAIL)   ? (r_do_dr ? DR_HDR : FINISH) :
                       (r_state == DR_HDR)    ? DR_SHIFT :
                       (r_state == DR_SHIFT)  ? DR_TAIL : FINISH;

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        case (r_state)
            IDLE: if (start) begin
                w_state_nxt = do_ir ? IR_HDR : do_dr ? DR_HDR : FINISH;
                w_bit_nxt   = '0;
            end
            FINISH: w_state_nxt = IDLE;
            default: if (w_end) begin
                w_bit_nxt = w_last ? '0 : r_bit + BW'(1);
                if (w_last) w_state_nxt = w_seq_nxt;
            end
        endcase
        TMS = (r_state == RESET_SEQ) ? !w_last :
              (r_state == IR_HDR)    ? (r_bit < BW'(2)) :
              (r_state == IR_SHIFT || r_state == DR_SHIFT) ? w_last :
              (r_state == IR_TAIL || r_state == DR_TAIL || r_state == DR_HDR) ? (r_bit == '0) : 1'b0;
        TDI = (r_state == IR_SHIFT) ? |(r_ir & (IR_W'(1) << r_bit)) :
              (r_state == DR_SHIFT) ? |(r_dr & (DR_MAXW'(1) << r_bit)) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RESET_SEQ;
            r_bit    <= '0;
            r_cnt    <= '0;
            r_tck    <= 1'b0;
            r_trst_n <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_ir     <= '0;
            r_dr     <= '0;
            r_n      <= '0;
            r_do_dr  <= 1'b0;
            r_ir_out <= '0;
            r_dr_out <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_bit    <= w_bit_nxt;
            r_trst_n <= !(w_state_nxt == RESET_SEQ && w_bit_nxt == '0);
            r_busy   <= w_state_nxt != IDLE;
            r_done   <= r_state == FINISH;
            if (w_accept) begin
                r_ir     <= ir_in;
                r_dr     <= dr_in;
                r_n      <= w_len;
                r_do_dr  <= do_dr;
                r_ir_out <= '0;
                r_dr_out <= '0;
                r_cnt    <= CW'(1);
                r_tck    <= 1'b0;
            end else if (w_run) begin
                // r_cnt==0 only right after rst: the reset sequence's first low phase starts here
                if (r_cnt == '0 || w_end) begin
                    r_cnt <= CW'(1);
                    r_tck <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_rise) begin
                        r_tck <= 1'b1;
                        if (r_state == IR_SHIFT) r_ir_out <= r_ir_out | (IR_W'(TDO) << r_bit);
                        if (r_state == DR_SHIFT) r_dr_out <= r_dr_out | (DR_MAXW'(TDO) << r_bit);
                    end
                end
            end else begin
                r_tck <= 1'b0;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign ir_out = r_ir_out;
    assign dr_out = r_dr_out;
    assign TCK    = r_tck;
    assign TRST_N = r_trst_n;
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: directed scans against hand-computed TMS/TDI sequences, captures and latencies.
module tb_jtag_scan_master;
    logic        clk = 0, rst = 1, start = 0, do_ir = 0, do_dr = 0;
    logic [3:0]  ir_in = '0;
    logic [5:0]  dr_len = '0;
    logic [31:0] dr_in = '0;
    logic        busy, done, TCK, TMS, TDI, TRST_N, TDO;
    logic [3:0]  ir_out;
    logic [31:0] dr_out;
    int          mode = 0;
    logic        bp = 0;
    int          n_pass = 0, n_chk = 0, n_tck = 0, n_done = 0;
    logic        tms_log [4096];
    logic        tdi_log [4096];
    int          lat, tcks;
    logic [63:0] tmsv, tdiv;
    int          d0;

    jtag_scan_master #(.CLK_DIV(2), .IR_W(4), .DR_MAXW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .do_ir(do_ir), .do_dr(do_dr),
        .ir_in(ir_in), .dr_len(dr_len), .dr_in(dr_in), .busy(busy), .done(done),
        .ir_out(ir_out), .dr_out(dr_out), .TCK(TCK), .TMS(TMS), .TDI(TDI),
        .TRST_N(TRST_N), .TDO(TDO)
    );

    always #5 clk = ~clk;

    // Target model: tied-1, one-bit bypass flop, or direct loopback
    always @(posedge TCK) bp <= TDI;
    assign TDO = (mode == 0) ? 1'b1 : (mode == 1) ? bp : TDI;

    always @(posedge TCK) begin
        tms_log[n_tck & 4095] = TMS;
        tdi_log[n_tck & 4095] = TDI;
        n_tck++;
    end

    always @(posedge clk) if (done) n_done++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic pack(input int base, input int cnt, output logic [63:0] tv, output logic [63:0] dv);
        tv = '0;
        dv = '0;
        for (int i = 0; i < cnt && i < 64; i++) begin
            tv[i] = tms_log[(base + i) & 4095];
            dv[i] = tdi_log[(base + i) & 4095];
        end
    endtask

    // Entered at a negedge with rst high; releases rst and checks the reset sequence
    task automatic reset_check(input string tag);
        int base, nb, nt;
        logic [63:0] tv, dv;
        chk({tag, "_vals"}, {TCK, TMS, TDI, TRST_N, busy, done, ir_out, dr_out},
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0});
        base = n_tck;
        nb = 0;
        nt = 0;
        rst = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!TRST_N) nt++;
            if (!busy) break;
            nb++;
        end
        chk({tag, "_busy_clks"}, 64'(nb), 64'd24);
        chk({tag, "_trst_clks"}, 64'(nt), 64'd4);
        chk({tag, "_tcks"}, 64'(n_tck - base), 64'd6);
        pack(base, n_tck - base, tv, dv);
        chk({tag, "_tms"}, tv, 64'h1F);
        @(negedge clk);
        chk({tag, "_idle"}, {TCK, TMS, TRST_N}, {1'b0, 1'b0, 1'b1});
    endtask

    task automatic run_cmd(input string tag, input bit di, input bit dd, input logic [3:0] ir,
                           input logic [5:0] len, input logic [31:0] dr, input int md,
                           output int l, output int tc, output logic [63:0] tv, output logic [63:0] dv);
        int base, dn;
        mode = md;
        do_ir = di;
        do_dr = dd;
        ir_in = ir;
        dr_len = len;
        dr_in = dr;
        start = 1;
        base = n_tck;
        dn = n_done;
        @(negedge clk);
        start = 0;
        chk({tag, "_busy_acc"}, 64'(busy), 64'd1);
        ir_in = ~ir;
        dr_in = ~dr;
        dr_len = 6'd1;
        do_ir = ~di;
        do_dr = ~dd;
        l = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            l++;
            start = (l == 20);
            if (done) break;
        end
        start = 0;
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        repeat (30) @(negedge clk);
        chk({tag, "_done_cnt"}, 64'(n_done - dn), 64'd1);
        tc = n_tck - base;
        pack(base, tc, tv, dv);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_check("rst1");

        run_cmd("ir", 1, 0, 4'hA, 6'd0, 32'h0, 0, lat, tcks, tmsv, tdiv);
        chk("ir_lat", 64'(lat), 64'd41);
        chk("ir_tcks", 64'(tcks), 64'd10);
        chk("ir_tms", tmsv, 64'h183);
        chk("ir_tdi", tdiv, 64'hA0);
        chk("ir_out", 64'(ir_out), 64'hF);

        run_cmd("dr", 0, 1, 4'h0, 6'd32, 32'hDEADBEEF, 1, lat, tcks, tmsv, tdiv);
        chk("dr_lat", 64'(lat), 64'd149);
        chk("dr_tcks", 64'(tcks), 64'd37);
        chk("dr_tms", tmsv, 64'h0000_000C_0000_0001);
        chk("dr_tdi", tdiv, 64'h0000_0006_F56D_F778);
        chk("dr_out", 64'(dr_out), 64'hBD5B7DDE);
        chk("dr_ir_cleared", 64'(ir_out), 64'h0);

        run_cmd("irdr", 1, 1, 4'h3, 6'd8, 32'h5A, 2, lat, tcks, tmsv, tdiv);
        chk("irdr_lat", 64'(lat), 64'd93);
        chk("irdr_tcks", 64'(tcks), 64'd23);
        chk("irdr_ir", 64'(ir_out), 64'h3);
        chk("irdr_dr", 64'(dr_out), 64'h5A);

        run_cmd("len0", 0, 1, 4'h0, 6'd0, 32'hFFFFFFFF, 2, lat, tcks, tmsv, tdiv);
        chk("len0_lat", 64'(lat), 64'd25);
        chk("len0_tcks", 64'(tcks), 64'd6);
        chk("len0_dr", 64'(dr_out), 64'h1);

        run_cmd("len40", 0, 1, 4'h0, 6'd40, 32'h12345678, 2, lat, tcks, tmsv, tdiv);
        chk("len40_tcks", 64'(tcks), 64'd37);
        chk("len40_dr", 64'(dr_out), 64'h12345678);

        run_cmd("noop", 0, 0, 4'h5, 6'd4, 32'h0, 2, lat, tcks, tmsv, tdiv);
        chk("noop_lat", 64'(lat), 64'd1);
        chk("noop_tcks", 64'(tcks), 64'd0);

        mode = 1;
        do_ir = 0;
        do_dr = 1;
        dr_len = 6'd32;
        dr_in = 32'hFFFF0000;
        start = 1;
        d0 = n_done;
        @(negedge clk);
        start = 0;
        repeat (20) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("abort_vals", {TCK, TMS, TRST_N, busy, done}, {1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        chk("abort_outs", {ir_out, dr_out}, 36'h0);
        @(negedge clk);
        reset_check("rst2");
        chk("abort_no_done", 64'(n_done - d0), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
